// File: rtl/roi_pixel_gate.sv
// Tracks pixel x/y in a raw stream and forwards only region-of-interest pixels to the analyzer.
// Optional macro ROI_FRAME_DECIMATE_EN adds a 4-bit `decimate` input: process one frame, skip `decimate`.
module roi_pixel_gate #(
  parameter int COORD_WIDTH     = 12,
  parameter int FRAME_CNT_WIDTH = 16
) (
  input  logic                       pixel_clock,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       frame_start,
  input  logic                       line_start,
  input  logic                       pixel_valid,
  input  logic [7:0]                 pixel_in,
  input  logic [COORD_WIDTH-1:0]     roi_x0,
  input  logic [COORD_WIDTH-1:0]     roi_y0,
  input  logic [COORD_WIDTH-1:0]     roi_width,
  input  logic [COORD_WIDTH-1:0]     roi_height,
  input  logic                       clear_req,
`ifdef ROI_FRAME_DECIMATE_EN
  input  logic [3:0]                 decimate,
`endif
  output logic [7:0]                 data,
  output logic                       data_valid,
  output logic                       start,
  output logic                       stop,
  output logic                       clear,
  output logic                       truncated,
  output logic [FRAME_CNT_WIDTH-1:0] frames_done
);

  typedef enum logic [2:0] {S_IDLE, S_ARMED, S_WAIT_ROI, S_ACTIVE, S_DONE} state_t;

  localparam logic [COORD_WIDTH:0]     ExtOne   = {{COORD_WIDTH{1'b0}}, 1'b1};
  localparam logic [COORD_WIDTH-1:0]   CoordOne = {{(COORD_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [FRAME_CNT_WIDTH-1:0] FcOne  = {{(FRAME_CNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                     r_state;
  logic [COORD_WIDTH-1:0]     r_x;
  logic [COORD_WIDTH-1:0]     r_y;
  logic                       r_firstLine;
  logic [COORD_WIDTH-1:0]     r_x0;
  logic [COORD_WIDTH-1:0]     r_y0;
  logic [COORD_WIDTH-1:0]     r_w;
  logic [COORD_WIDTH-1:0]     r_h;
  logic [7:0]                 r_data;
  logic                       r_dataValid;
  logic                       r_start;
  logic                       r_stop;
  logic                       r_lastSeen;
  logic                       r_clear;
  logic                       r_truncated;
  logic [FRAME_CNT_WIDTH-1:0] r_framesDone;

  logic [COORD_WIDTH:0] w_xExt;
  logic [COORD_WIDTH:0] w_yExt;
  logic [COORD_WIDTH:0] w_xEnd;
  logic [COORD_WIDTH:0] w_yEnd;
  logic                 w_inside;
  logic                 w_last;
  logic                 w_roiZero;
  logic                 w_skipFrame;
  logic                 w_newFrame;
  state_t               w_frameState;

  // Position counters and per-frame ROI snapshot; counters saturate instead of wrapping.
  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      r_x         <= '0;
      r_y         <= '0;
      r_firstLine <= 1'b1;
      r_x0        <= '0;
      r_y0        <= '0;
      r_w         <= '0;
      r_h         <= '0;
    end else if (frame_start) begin
      r_x         <= '0;
      r_y         <= '0;
      r_firstLine <= 1'b1;
      r_x0        <= roi_x0;
      r_y0        <= roi_y0;
      r_w         <= roi_width;
      r_h         <= roi_height;
    end else if (line_start) begin
      r_x <= '0;
      if (r_firstLine) begin
        r_firstLine <= 1'b0;
      end else if (!(&r_y)) begin
        r_y <= r_y + CoordOne;
      end
    end else if (pixel_valid && !(&r_x)) begin
      r_x <= r_x + CoordOne;
    end
  end

  assign w_xExt   = {1'b0, r_x};
  assign w_yExt   = {1'b0, r_y};
  assign w_xEnd   = {1'b0, r_x0} + {1'b0, r_w};
  assign w_yEnd   = {1'b0, r_y0} + {1'b0, r_h};
  assign w_inside = pixel_valid
                    && (w_xExt >= {1'b0, r_x0}) && (w_xExt < w_xEnd)
                    && (w_yExt >= {1'b0, r_y0}) && (w_yExt < w_yEnd);
  assign w_last   = w_inside && ((w_xExt + ExtOne) == w_xEnd) && ((w_yExt + ExtOne) == w_yEnd);
  assign w_roiZero  = (roi_width == '0) || (roi_height == '0);
  assign w_newFrame = frame_start && enable && (r_state != S_IDLE);

`ifdef ROI_FRAME_DECIMATE_EN
  logic [3:0] r_skipCnt;
  assign w_skipFrame = (r_skipCnt != 4'd0);
`else
  assign w_skipFrame = 1'b0;
`endif

  // Where a frame_start leads: skipped or zero-size frames park in ARMED so they emit nothing.
  always_comb begin
    w_frameState = S_WAIT_ROI;
    if (!enable) begin
      w_frameState = S_IDLE;
    end else if (w_skipFrame || w_roiZero) begin
      w_frameState = S_ARMED;
    end
  end

  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_data       <= '0;
      r_dataValid  <= 1'b0;
      r_start      <= 1'b0;
      r_stop       <= 1'b0;
      r_lastSeen   <= 1'b0;
      r_clear      <= 1'b0;
      r_truncated  <= 1'b0;
      r_framesDone <= '0;
`ifdef ROI_FRAME_DECIMATE_EN
      r_skipCnt    <= '0;
`endif
    end else begin
      r_dataValid <= 1'b0;
      r_start     <= 1'b0;
      r_stop      <= r_lastSeen;
      r_lastSeen  <= 1'b0;
      r_clear     <= clear_req;
      if (r_lastSeen) begin
        r_framesDone <= r_framesDone + FcOne;
      end
      case (r_state)
        S_IDLE: begin
          if (enable) r_state <= S_ARMED;
        end
        S_ARMED: begin
          if (!enable) begin
            r_state <= S_IDLE;
          end else if (frame_start) begin
            r_state <= w_frameState;
          end
        end
        S_WAIT_ROI: begin
          if (frame_start) begin
            r_state <= w_frameState;
          end else if (w_inside) begin
            r_start     <= 1'b1;
            r_dataValid <= 1'b1;
            r_data      <= pixel_in;
            r_lastSeen  <= w_last;
            r_state     <= w_last ? S_DONE : S_ACTIVE;
          end
        end
        S_ACTIVE: begin
          // A new frame before the ROI finished closes the window early and flags it.
          if (frame_start) begin
            r_state     <= w_frameState;
            r_stop      <= 1'b1;
            r_truncated <= 1'b1;
          end else if (w_inside) begin
            r_dataValid <= 1'b1;
            r_data      <= pixel_in;
            if (w_last) begin
              r_lastSeen <= 1'b1;
              r_state    <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (frame_start) r_state <= w_frameState;
        end
        default: r_state <= S_IDLE;
      endcase
`ifdef ROI_FRAME_DECIMATE_EN
      if (w_newFrame) begin
        r_skipCnt <= w_skipFrame ? (r_skipCnt - 4'd1) : decimate;
      end
`endif
      if (clear_req) begin
        r_truncated  <= 1'b0;
        r_framesDone <= '0;
      end
    end
  end

  assign data        = r_data;
  assign data_valid  = r_dataValid;
  assign start       = r_start;
  assign stop        = r_stop;
  assign clear       = r_clear;
  assign truncated   = r_truncated;
  assign frames_done = r_framesDone;

endmodule

// File: tb/tb_roi_pixel_gate.sv
// Directed self-checking bench for roi_pixel_gate using an 8x4 frame with pixel_in = x + 16*y.
`timescale 1ns/1ps
module tb_roi_pixel_gate;

  localparam int CW = 12;
  localparam int FW = 16;

  logic          pixel_clock = 1'b0;
  logic          reset;
  logic          enable;
  logic          frame_start;
  logic          line_start;
  logic          pixel_valid;
  logic [7:0]    pixel_in;
  logic [CW-1:0] roi_x0;
  logic [CW-1:0] roi_y0;
  logic [CW-1:0] roi_width;
  logic [CW-1:0] roi_height;
  logic          clear_req;
`ifdef ROI_FRAME_DECIMATE_EN
  logic [3:0]    decimate;
`endif
  logic [7:0]    data;
  logic          data_valid;
  logic          start;
  logic          stop;
  logic          clear;
  logic          truncated;
  logic [FW-1:0] frames_done;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int clashCnt = 0;
  int dvData[$];
  int dvCyc[$];
  int startCycQ[$];
  int stopCycQ[$];
  int clearCycQ[$];

  roi_pixel_gate #(.COORD_WIDTH(CW), .FRAME_CNT_WIDTH(FW)) dut (
    .pixel_clock (pixel_clock),
    .reset       (reset),
    .enable      (enable),
    .frame_start (frame_start),
    .line_start  (line_start),
    .pixel_valid (pixel_valid),
    .pixel_in    (pixel_in),
    .roi_x0      (roi_x0),
    .roi_y0      (roi_y0),
    .roi_width   (roi_width),
    .roi_height  (roi_height),
    .clear_req   (clear_req),
`ifdef ROI_FRAME_DECIMATE_EN
    .decimate    (decimate),
`endif
    .data        (data),
    .data_valid  (data_valid),
    .start       (start),
    .stop        (stop),
    .clear       (clear),
    .truncated   (truncated),
    .frames_done (frames_done)
  );

  always #5 pixel_clock = ~pixel_clock;

  always @(posedge pixel_clock) cyc++;

  // Record every output event with the period it appeared in, sampled mid-cycle.
  always @(negedge pixel_clock) begin
    if (data_valid) begin
      dvData.push_back(int'(data));
      dvCyc.push_back(cyc);
    end
    if (start) startCycQ.push_back(cyc);
    if (stop)  stopCycQ.push_back(cyc);
    if (clear) clearCycQ.push_back(cyc);
    if (start && stop) clashCnt++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one period of stimulus, then return 1ns after the sampling edge.
  task automatic applyStimulus(input logic fs, input logic ls, input logic pv, input logic [7:0] pix);
    frame_start = fs;
    line_start  = ls;
    pixel_valid = pv;
    pixel_in    = pix;
    @(posedge pixel_clock);
    #1;
    frame_start = 1'b0;
    line_start  = 1'b0;
    pixel_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic setRoi(input int x0, input int y0, input int w, input int h);
    roi_x0     = CW'(x0);
    roi_y0     = CW'(y0);
    roi_width  = CW'(w);
    roi_height = CW'(h);
  endtask

  task automatic startFrame(output int fsCyc);
    fsCyc = cyc;
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    idle(1);
  endtask

  task automatic sendLine(input int y);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    for (int x = 0; x < 8; x++) applyStimulus(1'b0, 1'b0, 1'b1, 8'(x + 16 * y));
    idle(1);
  endtask

  task automatic sendLines();
    for (int y = 0; y < 4; y++) sendLine(y);
    idle(2);
  endtask

  task automatic sendFrame(input bit chgRoi);
    int fsCyc;
    startFrame(fsCyc);
    if (chgRoi) setRoi(0, 0, 8, 4);
    sendLines();
  endtask

  task automatic checkRoiData(input int base, input string pfx);
    int expVals[6] = '{32'h12, 32'h13, 32'h14, 32'h22, 32'h23, 32'h24};
    for (int i = 0; i < 6; i++) begin
      checkOutput($sformatf("%s_data%0d", pfx, i),
                  (dvData.size() > base + i) ? dvData[base + i] : -1, expVals[i]);
    end
  endtask

  int dvB, stB, spB, fs2, cc;

  initial begin
    reset = 1'b1; enable = 1'b0; clear_req = 1'b0;
    frame_start = 1'b0; line_start = 1'b0; pixel_valid = 1'b0; pixel_in = 8'h00;
    setRoi(2, 1, 3, 2);
`ifdef ROI_FRAME_DECIMATE_EN
    decimate = 4'd2;
`endif
    repeat (3) @(posedge pixel_clock);
    #1;
    checkOutput("rst_data",        32'(data),        0);
    checkOutput("rst_data_valid",  32'(data_valid),  0);
    checkOutput("rst_start",       32'(start),       0);
    checkOutput("rst_stop",        32'(stop),        0);
    checkOutput("rst_clear",       32'(clear),       0);
    checkOutput("rst_truncated",   32'(truncated),   0);
    checkOutput("rst_frames_done", 32'(frames_done), 0);

    reset = 1'b0;
    enable = 1'b1;
    idle(3);

    // Normal ROI on one frame
    dvB = dvData.size(); stB = startCycQ.size(); spB = stopCycQ.size();
    sendFrame(1'b0);
    checkOutput("n_dvCount", dvData.size() - dvB, 6);
    checkRoiData(dvB, "n");
    checkOutput("n_startCount", startCycQ.size() - stB, 1);
    checkOutput("n_startAlign", (startCycQ.size() > stB) ? startCycQ[stB] : -1,
                (dvCyc.size() > dvB) ? dvCyc[dvB] : -2);
    checkOutput("n_stopCount", stopCycQ.size() - spB, 1);
    checkOutput("n_stopAlign", (stopCycQ.size() > spB) ? stopCycQ[spB] : -1,
                (dvCyc.size() > dvB + 5) ? dvCyc[dvB + 5] + 1 : -2);
    checkOutput("n_frames_done", 32'(frames_done), 1);

    // Second back-to-back frame
    sendFrame(1'b0);
    checkOutput("b2b_startCount", startCycQ.size() - stB, 2);
    checkOutput("b2b_stopCount",  stopCycQ.size() - spB, 2);
    checkOutput("b2b_frames_done", 32'(frames_done), 2);
    checkOutput("b2b_truncated",   32'(truncated),   0);

    // ROI taller than the frame, closed by the next frame_start
    setRoi(2, 1, 3, 6);
    dvB = dvData.size(); spB = stopCycQ.size();
    sendFrame(1'b0);
    checkOutput("oof_dvCount", dvData.size() - dvB, 9);
    checkOutput("oof_noStopYet", stopCycQ.size() - spB, 0);
    setRoi(2, 1, 3, 2);
    startFrame(fs2);
    checkOutput("oof_stopAlign", (stopCycQ.size() > spB) ? stopCycQ[spB] : -1, fs2 + 1);
    checkOutput("oof_truncated",   32'(truncated),   1);
    checkOutput("oof_frames_done", 32'(frames_done), 2);
    sendLines();
    checkOutput("oof_next_frames_done", 32'(frames_done), 3);
    checkOutput("oof_sticky", 32'(truncated), 1);

    // Zero-size ROI, then clear
    setRoi(2, 1, 0, 2);
    dvB = dvData.size(); stB = startCycQ.size(); spB = stopCycQ.size();
    sendFrame(1'b0);
    checkOutput("zero_dv",    dvData.size() - dvB, 0);
    checkOutput("zero_start", startCycQ.size() - stB, 0);
    checkOutput("zero_stop",  stopCycQ.size() - spB, 0);
    cc = cyc;
    clear_req = 1'b1;
    idle(1);
    clear_req = 1'b0;
    idle(1);
    checkOutput("clr_align", (clearCycQ.size() > 0) ? clearCycQ[clearCycQ.size() - 1] : -1, cc + 1);
    checkOutput("clr_count", clearCycQ.size(), 1);
    checkOutput("clr_frames_done", 32'(frames_done), 0);
    checkOutput("clr_truncated",   32'(truncated),   0);

    // ROI inputs change after frame_start; latched ROI must still apply
    setRoi(2, 1, 3, 2);
    dvB = dvData.size();
    sendFrame(1'b1);
    setRoi(2, 1, 3, 2);
    checkOutput("chg_dvCount", dvData.size() - dvB, 6);
    checkRoiData(dvB, "chg");
    checkOutput("chg_frames_done", 32'(frames_done), 1);

    // Reset in the middle of an ROI
    startFrame(fs2);
    sendLine(0);
    sendLine(1);
    spB = stopCycQ.size();
    reset = 1'b1;
    idle(1);
    checkOutput("mrst_data",        32'(data),        0);
    checkOutput("mrst_data_valid",  32'(data_valid),  0);
    checkOutput("mrst_start",       32'(start),       0);
    checkOutput("mrst_stop",        32'(stop),        0);
    checkOutput("mrst_frames_done", 32'(frames_done), 0);
    checkOutput("mrst_truncated",   32'(truncated),   0);
    reset = 1'b0;
    idle(6);
    checkOutput("mrst_noStop", stopCycQ.size() - spB, 0);

`ifdef ROI_FRAME_DECIMATE_EN
    // decimate=2 over six frames: frames 1 and 4 processed
    dvB = dvData.size(); stB = startCycQ.size();
    for (int f = 0; f < 6; f++) sendFrame(1'b0);
    checkOutput("dec_frames_done", 32'(frames_done), 2);
    checkOutput("dec_startCount", startCycQ.size() - stB, 2);
    checkOutput("dec_dvCount", dvData.size() - dvB, 12);
`endif

    checkOutput("pulse_clash", clashCnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
